// File: rtl/mux_n_to_1_rr_pkg.sv
// mux_n_to_1_rr shared types: mode encoding and select-width rule.
// sel_w(n) lets instantiating modules size sel/out_ch consistently.
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_n_to_1_rr_pick.sv
// rr_pick: combinational rotate/priority-find over N request lines.
// Ports: req, ptr (search start) -> gnt_idx, gnt_vld.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = sel_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_vld
);

    int k;

    // Walk offsets from farthest to nearest so the first hit after ptr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        k       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (req[k]) begin
                gnt_idx = SW'(k);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_rr.sv
// mux_n_to_1_rr: N-channel registered mux, fixed-select or round-robin.
// Ports: clk, rst_n, mode, sel, in_valid/in_data/in_ready (per channel),
//        out_valid/out_data/out_ch/out_ready (single output register).
// Option: define MUX_N_TO_1_PARITY_EN to add registered out_par (XOR of word).
module mux_n_to_1_rr
    import mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int WIDTH = 8,
    localparam int SEL_W = sel_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
`ifdef MUX_N_TO_1_PARITY_EN
    output logic                  out_par,
`endif
    output logic [SEL_W-1:0]      out_ch
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [N_CH-1:0]  fix_mask;
    logic [N_CH-1:0]  req;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             load_en;
    logic             xfer;
    logic             is_rr;

    assign is_rr = (mux_mode_e'(mode) == MODE_RR);

    // Out-of-range sel yields an all-zero mask, hence no grant.
    always_comb begin
        fix_mask = '0;
        for (int k = 0; k < N_CH; k++) begin
            fix_mask[k] = (int'(sel) == k);
        end
    end

    // FIXED reuses the picker with a one-hot request as a validity check.
    assign req      = is_rr ? in_valid : (in_valid & fix_mask);
    assign pick_ptr = is_rr ? ptr_q : '0;

    rr_pick #(
        .N (N_CH)
    ) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Nothing is accepted while reset is held.
    assign load_en = rst_n & (~vld_q | out_ready);
    assign xfer    = gnt_vld & load_en;

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N_CH; k++) begin
            in_ready[k] = xfer & (int'(gnt_idx) == k);
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        vld_d  = vld_q;
        data_d = data_q;
        ch_d   = ch_q;
        if (xfer) begin
            vld_d  = 1'b1;
            data_d = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            ch_d   = gnt_idx;
            if (is_rr) begin
                ptr_d = (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            ch_q   <= '0;
        end else begin
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            data_q <= data_d;
            ch_q   <= ch_d;
        end
    end

`ifdef MUX_N_TO_1_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (xfer) begin
            par_q <= ^data_d;
        end
    end

    assign out_par = par_q;
`endif

    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// tb_mux_n_to_1_rr: directed vectors for mux_n_to_1_rr (N=8 and N=5).
// Expected values are hand-computed constants in the stimulus.
module tb_mux_n_to_1_rr;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [2:0]  out_ch;
`ifdef MUX_N_TO_1_PARITY_EN
    logic        out_par;
    logic        out_par5;
`endif

    logic        mode5;
    logic [2:0]  sel5;
    logic [4:0]  in_valid5;
    logic [39:0] in_data5;
    logic [4:0]  in_ready5;
    logic        out_valid5;
    logic [7:0]  out_data5;
    logic        out_ready5;
    logic [2:0]  out_ch5;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_n_to_1_rr #(.N_CH(8), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef MUX_N_TO_1_PARITY_EN
        .out_par   (out_par),
`endif
        .out_ch    (out_ch)
    );

    mux_n_to_1_rr #(.N_CH(5), .WIDTH(8)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode5),
        .sel       (sel5),
        .in_valid  (in_valid5),
        .in_data   (in_data5),
        .in_ready  (in_ready5),
        .out_valid (out_valid5),
        .out_data  (out_data5),
        .out_ready (out_ready5),
`ifdef MUX_N_TO_1_PARITY_EN
        .out_par   (out_par5),
`endif
        .out_ch    (out_ch5)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ramp_lanes();
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
    endtask

    initial begin
        logic [2:0] exp_ch [4];
        exp_ch = '{3'd2, 3'd7, 3'd2, 3'd7};

        rst_n      = 1'b0;
        mode       = $urandom_range(0, 1);
        sel        = 3'($urandom);
        in_valid   = 8'($urandom) | 8'h01;
        in_data    = {$urandom, $urandom};
        out_ready  = $urandom_range(0, 1);
        mode5      = 1'b0;
        sel5       = 3'd6;
        in_valid5  = 5'h1f;
        in_data5   = 40'h55_44_33_22_11;
        out_ready5 = 1'b1;

        // Reset held with random inputs.
        repeat (3) step();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_ch", 32'(out_ch), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h0);

        // First FIXED load on lane 3.
        rst_n     = 1'b1;
        mode      = 1'b0;
        sel       = 3'd3;
        in_valid  = 8'h08;
        in_data   = '0;
        in_data[3*8 +: 8] = 8'h4f;
        out_ready = 1'b1;
        @(negedge clk);
        chk("first_ready", 32'(in_ready), 32'h08);
        step();
        chk("first_valid", 32'(out_valid), 32'h1);
        chk("first_data", 32'(out_data), 32'h4f);
        chk("first_ch", 32'(out_ch), 32'h3);
`ifdef MUX_N_TO_1_PARITY_EN
        chk("par_4f", 32'(out_par), 32'h1);
        sel      = 3'd0;
        in_valid = 8'h01;
        in_data[7:0] = 8'haa;
        step();
        chk("par_aa", 32'(out_par), 32'h0);
        in_data[7:0] = 8'hf5;
        step();
        chk("par_f5", 32'(out_par), 32'h0);
`endif

        // N_CH=5 with sel beyond the channel count never grants.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("n5_ready", 32'(in_ready5), 32'h0);
            step();
            chk("n5_valid", 32'(out_valid5), 32'h0);
        end

        // FIXED sweep, one sel per cycle.
        ramp_lanes();
        in_valid = 8'hff;
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            step();
            chk("sweep_data", 32'(out_data), 32'h10 + k);
            chk("sweep_ch", 32'(out_ch), 32'(k));
        end

        // RR with all channels requesting.
        mode = 1'b1;
        sel  = 3'd5;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rr_ch", 32'(out_ch), 32'(i % 8));
            chk("rr_data", 32'(out_data), 32'h10 + (i % 8));
        end

        // RR wrap-around between channels 2 and 7.
        in_valid = 8'b1000_0100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_wrap_ch", 32'(out_ch), 32'(exp_ch[i]));
        end

        // Drain, then backpressure after the first load (ptr is 0 here).
        in_valid = 8'h00;
        step();
        chk("drain_valid", 32'(out_valid), 32'h0);
        in_valid  = 8'hff;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_first_ready", 32'(in_ready), 32'h01);
        step();
        chk("bp_load_ch", 32'(out_ch), 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_ready", 32'(in_ready), 32'h0);
            step();
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_ch", 32'(out_ch), 32'h0);
            chk("bp_data", 32'(out_data), 32'h10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ready", 32'(in_ready), 32'h02);
        step();
        chk("bp_rel_ch", 32'(out_ch), 32'h1);

        // Asynchronous reset while full and stalled (ptr is 2 here).
        out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_data", 32'(out_data), 32'h0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'h01);
        step();
        chk("post_rst_ch", 32'(out_ch), 32'h0);
        step();
        chk("post_rst_ch2", 32'(out_ch), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
